// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and byte-stream geometry shared by the loader files.
package imem_loader_pkg;
   localparam int LANE_W = 8;
   typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream and control in, instruction-memory write port and core hold out.
interface imem_loader_if;
   import imem_loader_pkg::*;
   logic StartL, ByteValidL, ByteReadyL, IMemWE, HoldCore, LoadDone, LoadErr;
   logic [LANE_W-1:0] ByteInL;
   logic [31:0] IMemAddr, IMemWD;
   modport master(output StartL, ByteValidL, ByteInL,
                  input ByteReadyL, IMemWE, IMemAddr, IMemWD, HoldCore, LoadDone, LoadErr);
   modport slave(input StartL, ByteValidL, ByteInL,
                 output ByteReadyL, IMemWE, IMemAddr, IMemWD, HoldCore, LoadDone, LoadErr);
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// imem_loader_byte_assembler: packs little-endian bytes into 32-bit words, strobing on the 4th lane.
module imem_loader_byte_assembler
   import imem_loader_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              en,
   input  logic [LANE_W-1:0] byte_in,
   output logic              word_valid,
   output logic [31:0]       word
);
   logic [1:0] lane;
   logic [3*LANE_W-1:0] low;
   always_ff @(posedge CLK)
      if (RST || clr) lane <= '0;
      else if (en) lane <= lane + 2'd1;
   // bytes enter at the top and shift down, so lane 0 ends in bits [7:0]
   always_ff @(posedge CLK)
      if (en) low <= {byte_in, low[3*LANE_W-1:LANE_W]};
   assign word_valid = en && lane == 2'd3;
   assign word = {byte_in, low};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a word-count header plus data words into instruction memory, holding the core meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word before DONE.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input logic          CLK,
   input logic          RST,
   imem_loader_if.slave bus
);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   state_t state, nxt;
   logic [31:0] n, idx, word;
   logic word_valid, start, write, last;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CHK;
   logic [31:0] chk;
`else
   localparam state_t AFTER_DATA = DONE;
`endif
   assign start = bus.StartL && (state == IDLE || state == DONE || state == ERR);
   assign write = word_valid && state == DATA;
   assign last = idx + 32'd1 == n;
   imem_loader_byte_assembler u_asm (
      .CLK, .RST, .clr(start), .en(bus.ByteValidL && bus.ByteReadyL),
      .byte_in(bus.ByteInL), .word_valid, .word
   );
   always_comb begin
      nxt = state;
      if (start) nxt = HDR;
      else if (word_valid)
         case (state)
            HDR: nxt = word == '0 ? DONE : word > DEPTH_W ? ERR : DATA;
            DATA: nxt = last ? AFTER_DATA : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: nxt = word == chk ? DONE : ERR;
`endif
            default: nxt = state;
         endcase
   end
   // outputs are registered from the next state so they change together with it
   always_ff @(posedge CLK)
      if (RST) begin
         state <= IDLE;
         n <= '0;
         idx <= '0;
         bus.ByteReadyL <= 1'b0;
         bus.IMemWE <= 1'b0;
         bus.IMemAddr <= '0;
         bus.IMemWD <= '0;
         bus.HoldCore <= 1'b0;
         bus.LoadDone <= 1'b0;
         bus.LoadErr <= 1'b0;
      end else begin
         state <= nxt;
         bus.ByteReadyL <= nxt inside {HDR, DATA, CHK};
         bus.HoldCore <= !(nxt inside {IDLE, DONE});
         bus.LoadDone <= nxt == DONE;
         bus.LoadErr <= nxt == ERR;
         bus.IMemWE <= write;
         if (start) idx <= '0;
         if (word_valid && state == HDR) n <= word;
         if (write) begin
            bus.IMemAddr <= BASE_ADDR + (idx << 2);
            bus.IMemWD <= word;
            idx <= idx + 32'd1;
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge CLK)
      if (RST || start) chk <= '0;
      else if (write) chk <= chk ^ word;
`endif
endmodule
